// File: rtl/usb_tx_pkg.sv
// rtl/usb_tx_pkg.sv - shared register map, header magic and state encodings for the USB link
package usb_tx_pkg;

    // Word indices (byte offset / 4); the receive block decodes the same map
    localparam logic [2:0] REG_DATA   = 3'd1;
    localparam logic [2:0] REG_STATUS = 3'd2;
    localparam logic [2:0] REG_CTRL   = 3'd3;
    localparam logic [2:0] REG_LEN    = 3'd4;
    localparam logic [2:0] REG_PKTCNT = 3'd5;

    localparam int ST_SPACE = 0;
    localparam int ST_OPEN  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_ERR   = 3;
    localparam int ST_IDLE  = 4;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_PAD  = 2'd2
    } tx_state_e;

    function automatic logic [31:0] make_header(input logic [15:0] len);
        return {HDR_MAGIC, len};
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock 32-bit staging FIFO with occupancy count
module fifo_sync #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [31:0]                din,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       empty,
    output logic                       full
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/usb_tx.sv
// rtl/usb_tx.sv - CPU transmit register block: framing, staging FIFO and USB outbound push
module usb_tx
    import usb_tx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    output logic        out_push,
    input  logic        out_nfull,
    output logic [31:0] out_data
);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_e     state, state_n;
    logic [15:0]   remaining, remaining_n;
    logic          ovf, err;
    logic [31:0]   pkt_cnt;

    logic          bus_req, wr_en, rd_en;
    logic [2:0]    reg_idx;
    logic          w_data, w_len, w_ctrl;
    logic          space, fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    logic          fifo_push;
    logic [31:0]   fifo_din;
    logic          ovf_set, err_set, pkt_inc, flag_clr;
    logic [31:0]   rd_val;
    logic          unused_ok;

    assign bus_req  = mem_valid && !mem_ready;
    assign wr_en    = bus_req && (mem_wstrb != 4'b0);
    assign rd_en    = bus_req && (mem_wstrb == 4'b0);
    assign reg_idx  = mem_addr[4:2];
    assign w_data   = wr_en && (reg_idx == REG_DATA);
    assign w_len    = wr_en && (reg_idx == REG_LEN);
    assign w_ctrl   = wr_en && (reg_idx == REG_CTRL);
    assign flag_clr = w_ctrl && mem_wdata[0];

    // Space comes from the registered count, so a same-cycle pop never frees a slot
    assign space    = (fifo_count != CW'(DEPTH));
    assign out_push = !fifo_empty && out_nfull;
    assign unused_ok = &{1'b0, mem_addr[31:5], mem_addr[1:0], fifo_full};

    fifo_sync #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (out_push),
        .din   (fifo_din),
        .dout  (out_data),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        fifo_push   = 1'b0;
        fifo_din    = 32'h0;
        ovf_set     = 1'b0;
        err_set     = 1'b0;
        pkt_inc     = 1'b0;
        case (state)
            S_IDLE: begin
                if (w_len && mem_wdata[15:0] != 16'h0) begin
                    if (!space) begin
                        ovf_set = 1'b1;
                    end else begin
                        fifo_push   = 1'b1;
                        fifo_din    = make_header(mem_wdata[15:0]);
                        remaining_n = mem_wdata[15:0];
                        state_n     = S_OPEN;
                    end
                end
                if (w_data) err_set = 1'b1;
            end
            S_OPEN: begin
                if (w_data) begin
                    if (space) begin
                        fifo_push   = 1'b1;
                        fifo_din    = mem_wdata;
                        remaining_n = remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state_n = S_IDLE;
                            pkt_inc = 1'b1;
                        end
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                if (w_len) err_set = 1'b1;
                if (w_ctrl && mem_wdata[1]) state_n = S_PAD;
            end
            S_PAD: begin
                if (w_data || w_len) err_set = 1'b1;
                if (space) begin
                    fifo_push   = 1'b1;
                    remaining_n = remaining - 16'd1;
                    if (remaining == 16'd1) state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        rd_val = 32'h0;
        case (reg_idx)
            REG_STATUS: begin
                rd_val[ST_SPACE] = space;
                rd_val[ST_OPEN]  = (state != S_IDLE);
                rd_val[ST_OVF]   = ovf;
                rd_val[ST_ERR]   = err;
                rd_val[ST_IDLE]  = (state == S_IDLE) && fifo_empty;
            end
            REG_PKTCNT: rd_val = pkt_cnt;
            default:    rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            remaining <= 16'h0;
            ovf       <= 1'b0;
            err       <= 1'b0;
            pkt_cnt   <= 32'h0;
            mem_ready <= 1'b0;
            mem_rdata <= 32'h0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            // A fresh error outranks a clear arriving on the same edge
            if (ovf_set)       ovf <= 1'b1;
            else if (flag_clr) ovf <= 1'b0;
            if (err_set)       err <= 1'b1;
            else if (flag_clr) err <= 1'b0;
            if (pkt_inc) pkt_cnt <= pkt_cnt + 32'd1;
            mem_ready <= bus_req;
            mem_rdata <= rd_en ? rd_val : 32'h0;
        end
    end

endmodule

// File: tb/tb_usb_tx.sv
// tb/tb_usb_tx.sv - self-checking bench for usb_tx with a packet-level reference model
module tb_usb_tx;
    localparam logic [31:0] A_DATA   = 32'd4;
    localparam logic [31:0] A_STATUS = 32'd8;
    localparam logic [31:0] A_CTRL   = 32'd12;
    localparam logic [31:0] A_LEN    = 32'd16;
    localparam logic [31:0] A_PKTCNT = 32'd20;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        out_push;
    logic        out_nfull;
    logic [31:0] out_data;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] got_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] pkt_exp = 0;

    always #5 clk = ~clk;

    usb_tx #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .out_push  (out_push),
        .out_nfull (out_nfull),
        .out_data  (out_data)
    );

    always @(negedge clk) if (out_push) got_q.push_back(out_data);

    task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output logic [31:0] rdata);
        bit acked = 0;
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        rdata     = 32'h0;
        for (int i = 0; i < 16 && !acked; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                rdata = mem_rdata;
                acked = 1;
            end
        end
        if (!acked) begin
            checks++; failures++;
            $display("FAIL bus_timeout addr=%h no mem_ready within 16 cycles", addr);
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] dummy;
        bus(addr, wdata, 4'hF, dummy);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] rdata);
        bus(addr, 32'h0, 4'h0, rdata);
    endtask

    task automatic wait_words(input int n, input int budget);
        for (int i = 0; i < budget && got_q.size() < n; i++) begin
            @(posedge clk); #1;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic clear_streams();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic compare_stream(input string name);
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d exp=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL %s_word[%0d] got=%h exp=%h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1; mem_valid = 1'b0; mem_addr = 0; mem_wdata = 0; mem_wstrb = 0;
        out_nfull = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (mem_ready !== 1'b0 || mem_rdata !== 32'h0 || out_push !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got ready=%b rdata=%h push=%b exp 0/0/0",
                     mem_ready, mem_rdata, out_push);
        end
        rst = 1'b0;
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL reset_status got=%h exp=00000011", v); end
        rd(A_PKTCNT, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL reset_pktcnt got=%h exp=0", v); end
        rd(A_LEN, v);
        checks++;
        if (v !== 32'h0) begin failures++; $display("FAIL read_wo_len got=%h exp=0", v); end
    endtask

    task automatic test_basic();
        logic [31:0] v;
        clear_streams();
        wr(A_LEN, 32'd3);
        exp_q.push_back(32'hA55A0003);
        for (int i = 1; i <= 3; i++) begin
            wr(A_DATA, 32'h11 * i);
            exp_q.push_back(32'h11 * i);
        end
        pkt_exp++;
        wait_words(4, 100);
        compare_stream("basic");
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL basic_pktcnt got=%h exp=%h", v, pkt_exp); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL basic_status got=%h exp=00000011", v); end
    endtask

    task automatic test_random_packets();
        logic [31:0] v;
        int len, gap;
        logic [31:0] w;
        clear_streams();
        for (int p = 0; p < 8; p++) begin
            len = $urandom_range(1, 6);
            wr(A_LEN, len);
            exp_q.push_back({16'hA55A, 16'(len)});
            for (int k = 0; k < len; k++) begin
                w = $urandom;
                gap = $urandom_range(0, 3);
                repeat (gap) @(posedge clk);
                #1;
                wr(A_DATA, w);
                exp_q.push_back(w);
            end
            pkt_exp++;
        end
        wait_words(exp_q.size(), 400);
        compare_stream("random");
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL random_pktcnt got=%h exp=%h", v, pkt_exp); end
    endtask

    task automatic test_backpressure();
        logic [31:0] v;
        logic [31:0] d[7];
        clear_streams();
        wr(A_CTRL, 32'h1);
        out_nfull = 1'b0;
        for (int i = 0; i < 7; i++) d[i] = $urandom;
        wr(A_LEN, 32'd5);
        for (int i = 0; i < 5; i++) wr(A_DATA, d[i]);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h06) begin failures++; $display("FAIL bp_status got=%h exp=00000006", v); end
        checks++;
        if (got_q.size() !== 0) begin
            failures++; $display("FAIL bp_no_push got=%0d words exp=0", got_q.size());
        end
        out_nfull = 1'b1;
        exp_q.push_back(32'hA55A0005);
        for (int i = 0; i < 3; i++) exp_q.push_back(d[i]);
        wait_words(4, 50);
        compare_stream("bp_drain");
        wr(A_DATA, d[5]);
        wr(A_DATA, d[6]);
        exp_q.push_back(d[5]);
        exp_q.push_back(d[6]);
        pkt_exp++;
        wait_words(6, 50);
        compare_stream("bp_finish");
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL bp_pktcnt got=%h exp=%h", v, pkt_exp); end
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL bp_clear_status got=%h exp=00000011", v); end
    endtask

    task automatic test_abort();
        logic [31:0] v;
        clear_streams();
        wr(A_LEN, 32'd4);
        wr(A_DATA, 32'hAA);
        wr(A_CTRL, 32'h2);
        exp_q.push_back(32'hA55A0004);
        exp_q.push_back(32'hAA);
        for (int i = 0; i < 3; i++) exp_q.push_back(32'h0);
        wait_words(5, 50);
        compare_stream("abort");
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL abort_pktcnt got=%h exp=%h", v, pkt_exp); end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL abort_status got=%h exp=00000011", v); end
    endtask

    task automatic test_misuse();
        logic [31:0] v;
        clear_streams();
        wr(A_DATA, 32'hDEAD);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h19) begin failures++; $display("FAIL misuse_idle_data got=%h exp=00000019", v); end
        wr(A_CTRL, 32'h1);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL misuse_clear got=%h exp=00000011", v); end
        wr(A_CTRL, 32'h2);
        wr(A_STATUS, 32'hFFFF_FFFF);
        wr(A_LEN, 32'd2);
        wr(A_LEN, 32'd7);
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h0B) begin failures++; $display("FAIL misuse_open_len got=%h exp=0000000b", v); end
        wr(A_DATA, 32'h1234);
        wr(A_DATA, 32'h5678);
        exp_q.push_back(32'hA55A0002);
        exp_q.push_back(32'h1234);
        exp_q.push_back(32'h5678);
        pkt_exp++;
        wait_words(3, 50);
        compare_stream("misuse");
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h19) begin failures++; $display("FAIL misuse_sticky got=%h exp=00000019", v); end
        wr(A_CTRL, 32'h1);
    endtask

    task automatic test_len_zero();
        logic [31:0] v;
        clear_streams();
        wr(A_LEN, 32'h0);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() !== 0) begin
            failures++; $display("FAIL len0_push got=%0d words exp=0", got_q.size());
        end
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL len0_status got=%h exp=00000011", v); end
    endtask

    task automatic test_long_packet();
        logic [31:0] v;
        logic [31:0] w;
        clear_streams();
        wr(A_LEN, 32'd300);
        exp_q.push_back(32'hA55A012C);
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            wr(A_DATA, w);
            exp_q.push_back(w);
        end
        pkt_exp++;
        wait_words(301, 100);
        compare_stream("long");
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL long_pktcnt got=%h exp=%h", v, pkt_exp); end
    endtask

    task automatic test_max_len_pad();
        logic [31:0] v;
        int nonzero = 0;
        clear_streams();
        wr(A_LEN, 32'hFFFF);
        wr(A_DATA, 32'h5);
        wr(A_CTRL, 32'h2);
        wait_words(65536, 70000);
        checks++;
        if (got_q.size() !== 65536) begin
            failures++; $display("FAIL maxpad_len got=%0d exp=65536", got_q.size());
        end
        checks++;
        if (got_q.size() < 2 || got_q[0] !== 32'hA55AFFFF || got_q[1] !== 32'h5) begin
            failures++; $display("FAIL maxpad_head got=%h,%h exp=a55affff,00000005", got_q[0], got_q[1]);
        end
        for (int i = 2; i < got_q.size(); i++) if (got_q[i] !== 32'h0) nonzero++;
        checks++;
        if (nonzero !== 0) begin failures++; $display("FAIL maxpad_zeros got=%0d nonzero exp=0", nonzero); end
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL maxpad_pktcnt got=%h exp=%h", v, pkt_exp); end
    endtask

    task automatic test_pktcnt_wrap();
        logic [31:0] v;
        clear_streams();
        force dut.pkt_cnt = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.pkt_cnt;
        rd(A_PKTCNT, v);
        checks++;
        if (v !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=ffffffff", v); end
        wr(A_LEN, 32'd1);
        wr(A_DATA, 32'h77);
        pkt_exp = 32'h0;
        wait_words(2, 50);
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL wrap_pktcnt got=%h exp=%h", v, pkt_exp); end
    endtask

    task automatic test_reset_mid_pad();
        logic [31:0] v;
        clear_streams();
        wr(A_LEN, 32'd20);
        wr(A_DATA, 32'h1);
        wr(A_CTRL, 32'h2);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_push !== 1'b0) begin failures++; $display("FAIL rstpad_push got=%b exp=0", out_push); end
        rst = 1'b0;
        pkt_exp = 0;
        rd(A_STATUS, v);
        checks++;
        if (v !== 32'h11) begin failures++; $display("FAIL rstpad_status got=%h exp=00000011", v); end
        rd(A_PKTCNT, v);
        checks++;
        if (v !== pkt_exp) begin failures++; $display("FAIL rstpad_pktcnt got=%h exp=%h", v, pkt_exp); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random_packets();
        test_backpressure();
        test_abort();
        test_misuse();
        test_len_zero();
        test_long_packet();
        test_max_len_pad();
        test_pktcnt_wrap();
        test_reset_mid_pad();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/usb_tx.md
# usb_tx

CPU-side transmit register block for the USB link, the outbound counterpart of the receive register block. Firmware opens a packet by writing a length, then writes payload words. The block prepends a framing header, stages the words in a small FIFO, and pushes them into the USB outbound FIFO. Truncated packets are zero-padded and misuse is flagged with sticky error bits.

## Interface
- DEPTH, 4: staging FIFO entries; power of two, at least 2.
- clk  in  1: clock.
- rst  in  1: synchronous, active-high reset.
- mem_valid  in  1: bus request.
- mem_ready  out  1: bus acknowledge.
- mem_addr  in  32: byte address; the block decodes the low bits.
- mem_wdata  in  32: write data.
- mem_wstrb  in  4: byte strobes; nonzero means write, zero means read.
- mem_rdata  out  32: read data.
- out_push  out  1: push strobe to the USB outbound FIFO.
- out_nfull  in  1: USB outbound FIFO has space.
- out_data  out  32: word being pushed.

## Operation
- Register map (byte offsets):
  - 4*1 DATA (write): payload word.
  - 4*2 STATUS (read):
    - bit0 space: staging FIFO not full.
    - bit1 open: state is not IDLE.
    - bit2 ovf: sticky.
    - bit3 err: sticky.
    - bit4 idle: state is IDLE and staging FIFO empty.
  - 4*3 CTRL (write): bit0 clears ovf and err; bit1 aborts the open packet.
  - 4*4 LEN (write): wdata[15:0] is the payload word count.
  - 4*5 PKTCNT (read): count of completed packets, 32-bit, wraps.
  - Reads of write-only offsets return 0. Writes to read-only offsets are ignored.
- Input FSM states: IDLE, OPEN, PAD. The 16-bit counter `remaining` holds payload words still owed.
- IDLE:
  - LEN write with len≠0 and space=1: push header {16'hA55A, len}, set remaining=len, go to OPEN.
  - LEN write with len=0: ignored, no flags.
  - LEN write with space=0: set ovf, stay in IDLE.
  - DATA write: set err, word dropped.
- OPEN:
  - DATA write with space=1: push the word, decrement remaining. On remaining==1, go to IDLE and increment PKTCNT.
  - DATA write with space=0: set ovf, word dropped, remaining unchanged.
  - LEN write: set err, ignored.
  - CTRL.bit1: go to PAD.
- PAD:
  - Each cycle with space=1: push 32'h0 and decrement remaining. On remaining==1, go to IDLE. PKTCNT is not incremented.
  - DATA and LEN writes: set err, ignored.
- CTRL.bit1 outside OPEN is a no-op. CTRL.bit0 and a new error in the same cycle: the error wins.
- Output side: out_push = staging FIFO not empty && out_nfull. out_data = FIFO head. The FIFO pops on out_push.

## Timing
- Bus:
  - mem_ready is registered: high exactly one cycle, the cycle after mem_valid is sampled with mem_ready low. Back-to-back requests are therefore acknowledged every other cycle.
  - mem_rdata is registered alongside mem_ready and is 0 when mem_ready is low.
  - Write side effects take place in the same clock edge that raises mem_ready.
- space is evaluated from the registered FIFO count before this cycle's pop. A full FIFO rejects a push even when a pop happens in the same cycle.
- The earliest a pushed word can appear on out_push is the next cycle. The header of a LEN write reaches out_push two cycles after mem_valid if out_nfull=1.
- PAD pushes one word per cycle while space=1.
- Reset values:
  - mem_ready=0, mem_rdata=0.
  - out_push=0 (FIFO empty).
  - State IDLE, remaining=0, ovf=0, err=0, PKTCNT=0.
  - Staging FIFO flushed.
  - Reset mid-packet discards staged words. No padding is generated.
- PKTCNT wraps from 0xFFFFFFFF to 0.

## Structure
- The shared include holds:
  - register offsets (DATA, STATUS, CTRL, LEN, PKTCNT) and STATUS bit indices;
  - header magic 16'hA55A;
  - the state encodings.
- The receive side uses the same offsets and magic.
- Sub-module `fifo_sync` (parameter DEPTH, 32-bit):
  - ports push/pop/din/dout/count, with empty and full outputs;
  - pointers wrap modulo DEPTH;
  - count ranges 0..DEPTH.
- Bus decode, FSM, counters and flags live in usb_tx.

## Test plan
- Basic packet: LEN=3, DATA 0x11,0x22,0x33, out_nfull=1 -> out stream A55A0003,00000011,00000022,00000033. PKTCNT=1, idle=1.
- Backpressure: out_nfull=0, LEN=5, then 5 DATA writes with DEPTH=4 -> 3 words accepted, remaining writes set ovf, state still OPEN. Release out_nfull -> the 4 staged words drain in order.
- Abort: LEN=4, DATA 0xAA, CTRL=2 -> out A55A0004,000000AA,0,0,0. PKTCNT unchanged, idle=1.
- Misuse: DATA while IDLE -> err=1. LEN while OPEN -> err=1, packet continues. CTRL=1 -> err=0, ovf=0.
- Edges:
  - LEN=0 -> no push.
  - LEN=0xFFFF with continuous DATA -> PKTCNT increments once.
  - PKTCNT forced to 0xFFFFFFFF -> next complete packet reads 0.
- Reset mid-PAD -> out_push=0 the next cycle, STATUS reads 0x11.
